// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder: oversampled JTAG TAP with IR, BYPASS, user DR write port; IDCODE built only with JTAG_TAP_IDCODE_EN
module jtag_tap_responder #(
  parameter int                  IR_WIDTH     = 5,
  parameter logic [31:0]         IDCODE_VALUE = 32'h0000_0001,
  parameter logic [IR_WIDTH-1:0] USER_IR      = 5'h11,
  parameter int                  DR_WIDTH     = 41
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jtag_TCK,
  input  logic                jtag_TMS,
  input  logic                jtag_TDI,
  input  logic                jtag_TRSTn,
  output logic                jtag_TDO_data,
  output logic                jtag_TDO_driven,
  output logic                dr_out_valid,
  input  logic                dr_out_ready,
  output logic [DR_WIDTH-1:0] dr_out_data,
  input  logic [DR_WIDTH-1:0] dr_in_data,
  output logic                overrun,
  output logic [3:0]          tap_state
);
  typedef enum logic [3:0] {
    EX2_DR = 4'h0, EX1_DR = 4'h1, SH_DR  = 4'h2, PAU_DR = 4'h3,
    SEL_IR = 4'h4, UPD_DR = 4'h5, CAP_DR = 4'h6, SEL_DR = 4'h7,
    EX2_IR = 4'h8, EX1_IR = 4'h9, SH_IR  = 4'hA, PAU_IR = 4'hB,
    RTI    = 4'hC, UPD_IR = 4'hD, CAP_IR = 4'hE, TLR    = 4'hF
  } tap_e;
`ifdef JTAG_TAP_IDCODE_EN
  localparam int SW = DR_WIDTH > 32 ? DR_WIDTH : 32;
  localparam logic [IR_WIDTH-1:0] RST_IR = IR_WIDTH'(1);
`else
  localparam int SW = DR_WIDTH;
  localparam logic [IR_WIDTH-1:0] RST_IR = '1;
`endif
  tap_e                state_q, state_d, nxt;
  logic                tck_q, tdo_q, tdo_d, drv_q, drv_d, valid_q, valid_d, ovr_q, ovr_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sh_q, ir_sh_d;
  logic [SW-1:0]       dr_sh_q, dr_sh_d, cap, idc_cap, top;
  logic [DR_WIDTH-1:0] data_q, data_d;
  logic                rise, fall, is_idc, is_user, shifting, upd_user, accept;
  int                  dr_len;
  assign rise = jtag_TCK & ~tck_q;
  assign fall = ~jtag_TCK & tck_q;
`ifdef JTAG_TAP_IDCODE_EN
  assign is_idc  = ir_q == IR_WIDTH'(1);
  assign idc_cap = SW'(IDCODE_VALUE);
`else
  logic unused_idcode;
  assign is_idc        = 1'b0;
  assign idc_cap       = '0;
  assign unused_idcode = ^IDCODE_VALUE;
`endif
  assign is_user = !is_idc && ir_q == USER_IR && ir_q != '1;
  assign dr_len  = is_user ? DR_WIDTH : is_idc ? 32 : 1;
  assign cap     = is_user ? SW'(dr_in_data) : is_idc ? idc_cap : '0;
  assign top     = SW'(1) << (dr_len - 1);
  // standard 1149.1 successor of the current state for the sampled TMS
  always_comb begin
    nxt = state_q;
    case (state_q)
      TLR:    nxt = jtag_TMS ? TLR    : RTI;
      RTI:    nxt = jtag_TMS ? SEL_DR : RTI;
      SEL_DR: nxt = jtag_TMS ? SEL_IR : CAP_DR;
      CAP_DR: nxt = jtag_TMS ? EX1_DR : SH_DR;
      SH_DR:  nxt = jtag_TMS ? EX1_DR : SH_DR;
      EX1_DR: nxt = jtag_TMS ? UPD_DR : PAU_DR;
      PAU_DR: nxt = jtag_TMS ? EX2_DR : PAU_DR;
      EX2_DR: nxt = jtag_TMS ? UPD_DR : SH_DR;
      UPD_DR: nxt = jtag_TMS ? SEL_DR : RTI;
      SEL_IR: nxt = jtag_TMS ? TLR    : CAP_IR;
      CAP_IR: nxt = jtag_TMS ? EX1_IR : SH_IR;
      SH_IR:  nxt = jtag_TMS ? EX1_IR : SH_IR;
      EX1_IR: nxt = jtag_TMS ? UPD_IR : PAU_IR;
      PAU_IR: nxt = jtag_TMS ? EX2_IR : PAU_IR;
      EX2_IR: nxt = jtag_TMS ? UPD_IR : SH_IR;
      UPD_IR: nxt = jtag_TMS ? SEL_DR : RTI;
      default: nxt = TLR;
    endcase
  end
  // rise-driven capture/shift, fall-driven TDO/update, TRSTn trap and write handshake
  always_comb begin
    state_d  = !jtag_TRSTn ? TLR : rise ? nxt : state_q;
    shifting = state_q == SH_DR || state_q == SH_IR;
    upd_user = fall && state_q == UPD_DR && is_user;
    accept   = upd_user && (!valid_q || dr_out_ready);
    valid_d  = accept ? 1'b1 : (valid_q && dr_out_ready) ? 1'b0 : valid_q;
    data_d   = accept ? dr_sh_q[DR_WIDTH-1:0] : data_q;
    ovr_d    = (fall && state_q == UPD_IR) ? 1'b0 : (upd_user && !accept) ? 1'b1 : ovr_q;
    tdo_d    = (fall && shifting) ? (state_q == SH_IR ? ir_sh_q[0] : dr_sh_q[0]) : tdo_q;
    drv_d    = !jtag_TRSTn ? 1'b0 : fall ? shifting : drv_q;
    ir_sh_d  = (rise && state_q == CAP_IR) ? IR_WIDTH'(1) :
               (rise && state_q == SH_IR) ? {jtag_TDI, ir_sh_q[IR_WIDTH-1:1]} : ir_sh_q;
    dr_sh_d  = (rise && state_q == CAP_DR) ? cap :
               (rise && state_q == SH_DR) ? (((dr_sh_q >> 1) & ~top) | (jtag_TDI ? top : '0)) : dr_sh_q;
    ir_d     = state_d == TLR ? RST_IR : (fall && state_q == UPD_IR) ? ir_sh_q : ir_q;
    if (!jtag_TRSTn) begin
      ir_sh_d = '0;
      dr_sh_d = '0;
    end
  end
  // state register with asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= TLR;
      tck_q   <= 1'b0;
      ir_q    <= RST_IR;
      ir_sh_q <= '0;
      dr_sh_q <= '0;
      tdo_q   <= 1'b0;
      drv_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tck_q   <= jtag_TCK;
      ir_q    <= ir_d;
      ir_sh_q <= ir_sh_d;
      dr_sh_q <= dr_sh_d;
      tdo_q   <= tdo_d;
      drv_q   <= drv_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
    end
  end
  assign jtag_TDO_data   = tdo_q;
  assign jtag_TDO_driven = drv_q;
  assign dr_out_valid    = valid_q;
  assign dr_out_data     = data_q;
  assign overrun         = ovr_q;
  assign tap_state       = state_q;
endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder: directed scans of jtag_tap_responder with a queued scoreboard of expected TDO words
module tb_jtag_tap_responder;
  logic        clock = 0, reset = 0;
  logic        jtag_TCK = 0, jtag_TMS = 1, jtag_TDI = 0, jtag_TRSTn = 1;
  logic        jtag_TDO_data, jtag_TDO_driven, dr_out_valid, overrun;
  logic        dr_out_ready = 0;
  logic [40:0] dr_out_data, dr_in_data = '0;
  logic [3:0]  tap_state;
  logic [63:0] exp_q[$];
  int          n_cmp = 0, n_err = 0;
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [63:0] IDW = 64'h1;
`else
  localparam logic [63:0] IDW = 64'h0;
`endif
  jtag_tap_responder dut (
    .clock(clock), .reset(reset),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI), .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO_data(jtag_TDO_data), .jtag_TDO_driven(jtag_TDO_driven),
    .dr_out_valid(dr_out_valid), .dr_out_ready(dr_out_ready), .dr_out_data(dr_out_data),
    .dr_in_data(dr_in_data), .overrun(overrun), .tap_state(tap_state)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tck(input bit tms, input bit tdi, input bit rp);
    @(negedge clock);
    jtag_TMS = tms;
    jtag_TDI = tdi;
    jtag_TCK = 1;
    repeat (3) @(negedge clock);
    jtag_TCK = 0;
    if (rp) dr_out_ready = 1;
    @(negedge clock);
    if (rp) dr_out_ready = 0;
    repeat (2) @(negedge clock);
  endtask
  task automatic scan(input string tag, input bit ir, input int n, input logic [63:0] tv,
                      input logic [63:0] ev, input bit rp);
    logic [63:0] got, m;
    bit          drv_all;
    m = n == 64 ? '1 : (64'h1 << n) - 1;
    exp_q.push_back(ev & m);
    got = '0;
    drv_all = 1;
    tck(1, 0, 0);
    if (ir) tck(1, 0, 0);
    tck(0, 0, 0);
    tck(0, 0, 0);
    chk({tag, "_state"}, 64'(tap_state), ir ? 64'hA : 64'h2);
    got[0] = jtag_TDO_data;
    drv_all &= jtag_TDO_driven;
    for (int i = 0; i < n; i++) begin
      tck(i == n - 1, tv[i], 0);
      if (i < n - 1) begin
        got[i+1] = jtag_TDO_data;
        drv_all &= jtag_TDO_driven;
      end
    end
    chk({tag, "_driven"}, {62'h0, drv_all, jtag_TDO_driven}, 64'h2);
    tck(1, 0, rp);
    tck(0, 0, 0);
    chk(tag, got & m, exp_q.pop_front());
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_state", 64'(tap_state), 64'hF);
    chk("rst_outs", {59'h0, jtag_TDO_data, jtag_TDO_driven, dr_out_valid, overrun}, 64'h0);
    chk("rst_data", 64'(dr_out_data), 64'h0);
    reset = 1;
    repeat (5) tck(1, 0, 0);
    chk("tlr_state", 64'(tap_state), 64'hF);
    tck(0, 0, 0);
    chk("rti_state", 64'(tap_state), 64'hC);
    scan("idcode_dr", 0, 32, 64'h0, IDW, 0);
    scan("ir_1f", 1, 5, 64'h1F, 64'h1, 0);
    scan("bypass_dr", 0, 4, 64'hD, 64'hA, 0);
    scan("ir_user", 1, 5, 64'h11, 64'h1, 0);
    dr_in_data = 41'h0AA;
    scan("user_dr1", 0, 41, 64'h1_2345_6789A, 64'h0AA, 0);
    chk("upd1_valid", {62'h0, dr_out_valid, overrun}, 64'h2);
    chk("upd1_data", 64'(dr_out_data), 64'h1_2345_6789A);
    dr_in_data = 41'h155;
    scan("user_dr2", 0, 41, 64'h0_0F0F_0F0F0, 64'h155, 0);
    chk("ovr_flags", {62'h0, dr_out_valid, overrun}, 64'h3);
    chk("ovr_data", 64'(dr_out_data), 64'h1_2345_6789A);
    @(negedge clock);
    dr_out_ready = 1;
    @(negedge clock);
    chk("ready_clear", 64'(dr_out_valid), 64'h0);
    dr_out_ready = 0;
    scan("ir_user2", 1, 5, 64'h11, 64'h1, 0);
    chk("updir_clr_ovr", 64'(overrun), 64'h0);
    dr_in_data = 41'h0;
    scan("user_dr3", 0, 41, 64'h0_5555_AAAA1, 64'h0, 0);
    chk("upd3_data", 64'(dr_out_data), 64'h0_5555_AAAA1);
    scan("user_dr4", 0, 41, 64'h1_FFFF_0000F, 64'h0, 1);
    chk("simul_flags", {62'h0, dr_out_valid, overrun}, 64'h2);
    chk("simul_data", 64'(dr_out_data), 64'h1_FFFF_0000F);
    @(negedge clock);
    dr_out_ready = 1;
    @(negedge clock);
    dr_out_ready = 0;
    tck(1, 0, 0);
    tck(0, 0, 0);
    tck(0, 0, 0);
    tck(0, 1, 0);
    chk("pre_trst", {60'h0, tap_state}, 64'h2);
    @(negedge clock);
    jtag_TRSTn = 0;
    @(negedge clock);
    chk("trst_state", {59'h0, jtag_TDO_driven, tap_state}, 64'hF);
    jtag_TRSTn = 1;
    tck(0, 0, 0);
    scan("trst_ir_dr", 0, 32, 64'h0, IDW, 0);
    scan("ir_user3", 1, 5, 64'h11, 64'h1, 0);
    dr_in_data = 41'h1;
    scan("user_dr5", 0, 41, 64'h1, 64'h1, 0);
    scan("user_dr6", 0, 41, 64'h2, 64'h1, 0);
    chk("pre_rst_flags", {62'h0, dr_out_valid, overrun}, 64'h3);
    tck(1, 0, 0);
    tck(0, 0, 0);
    tck(0, 0, 0);
    chk("pre_rst_tdo", {58'h0, jtag_TDO_data, jtag_TDO_driven, tap_state}, 64'h32);
    @(negedge clock);
    reset = 0;
    #1;
    chk("async_state", 64'(tap_state), 64'hF);
    chk("async_outs", {59'h0, jtag_TDO_data, jtag_TDO_driven, dr_out_valid, overrun}, 64'h0);
    chk("async_data", 64'(dr_out_data), 64'h0);
    @(negedge clock);
    reset = 1;
    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/jtag_tap_responder.md
# jtag_tap_responder

- Target-side JTAG TAP controller: the responder to the simulation JTAG driver.
- Oversamples the driver's TCK, TMS, TDI and TRSTn on the system clock. Runs the IEEE 1149.1 16-state TAP machine with IR, BYPASS, IDCODE and one user data register (DR), and returns TDO with a driven flag.
- The user DR connects to a debug-module-style client through a valid/ready write port and a sampled read word. The block sits between the JTAG pin bundle and the debug-transport logic in the simulation top.

## Interface
- `IR_WIDTH`, 5: instruction register width.
- `IDCODE_VALUE`, 32'h0000_0001: IDCODE word. Bit 0 must be 1.
- `USER_IR`, 5'h11: opcode selecting the user DR.
- `DR_WIDTH`, 41: user DR length. Legal range 1..64.
- `clock` in 1: system clock. All state is in this domain.
- `reset` in 1: asynchronous, active-low reset.
- `jtag_TCK`, `jtag_TMS`, `jtag_TDI`, `jtag_TRSTn` in 1 each: pins from the driver. Treated as synchronous to `clock`.
- `jtag_TDO_data` out 1: TDO value.
- `jtag_TDO_driven` out 1: high while the TAP is in Shift-DR or Shift-IR.
- `dr_out_valid` out 1 / `dr_out_ready` in 1 / `dr_out_data` out DR_WIDTH: user-DR write port.
- `dr_in_data` in DR_WIDTH: value loaded at Capture-DR.
- `overrun` out 1: sticky flag for a dropped Update-DR.
- `tap_state` out 4: current TAP state, for debug.

## Operation
- Edge detect: `tck_q` registers `jtag_TCK`.
  - rise = TCK & ~tck_q.
  - fall = ~TCK & tck_q.
  - TMS and TDI are sampled in the cycle rise is asserted.
- The FSM advances on rise only. States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, and the IR mirror states, with standard 1149.1 transitions.
- Trap on TRSTn: `jtag_TRSTn`=0 forces TLR, IR=IDCODE and clears the shift registers. It overrides rise.
- Encoding is the 1149.1 state encoding on `tap_state`: TLR=0xF, RTI=0xC, ShDR=0x2, ShIR=0xA, UpdDR=0x5, UpdIR=0xD.
- Instruction handling:
  - Entering TLR loads IR = IDCODE opcode (5'h01).
  - CapIR on rise loads the IR shift register with ...00001.
  - ShIR on rise shifts right, with TDI entering the MSB.
  - UpdIR on fall copies the shift register to IR and clears `overrun`.
  - Decode: all-ones selects BYPASS, 5'h01 selects IDCODE, USER_IR selects USER. Any other opcode selects BYPASS.
- DR lengths and capture values:
  - BYPASS: 1 bit, captures 0.
  - IDCODE: 32 bits, captures IDCODE_VALUE.
  - USER: DR_WIDTH bits, captures `dr_in_data`.
- DR shift: in ShDR on rise, shift right and insert TDI at bit (len-1).
- TDO: on fall, `jtag_TDO_data` <= shift register bit 0 (IR or DR per state), and `jtag_TDO_driven` <= (state is ShDR or ShIR). On other falls the data holds its value and the driven flag is 0.
- Update-DR with USER, on the first fall in UpdDR:
  - If `dr_out_valid`=0: load `dr_out_data` <= shift[DR_WIDTH-1:0] and set valid.
  - Else: drop the update and set `overrun`.
- Write handshake: valid clears the cycle after valid & ready. Data is stable while valid.
- Update-DR under BYPASS or IDCODE has no effect.

## Timing
- Reset values: state=TLR, IR=IDCODE opcode, tck_q=0, all shift registers 0, `jtag_TDO_data`=0, `jtag_TDO_driven`=0, `dr_out_valid`=0, `dr_out_data`=0, `overrun`=0.
- Latency from the cycle a TCK edge is seen to the visible result: 1 clock.
  - Rise: `tap_state` updates 1 clock later.
  - Fall: TDO and `dr_out_valid` update 1 clock later.
- TCK must hold each level for at least 2 clocks. Faster toggling is unsupported.
- Simultaneous valid&ready and Update-DR fall in the same cycle: the handshake completes and the new update is accepted. No overrun.
- `reset` asserted mid-scan: all state returns to reset values immediately. A pending write is lost.

## Configuration
- `JTAG_TAP_IDCODE_EN` defined: IDCODE instruction present, and TLR loads the IDCODE opcode.
- Undefined:
  - Opcode 5'h01 decodes as BYPASS.
  - TLR loads the all-ones (BYPASS) opcode.
  - No 32-bit IDCODE path is built.
  - `IDCODE_VALUE` is ignored.

## Test plan
- Reset, then 5 TCK cycles with TMS=1 -> `tap_state`=0xF, IR=5'h01, all outputs at reset values.
- From TLR, walk to ShDR and shift 32 bits of TDI=0 -> TDO returns 32'h0000_0001 LSB first, and `jtag_TDO_driven`=1 only during ShDR.
- IR scan of 5'h1F -> captured TDO bits are 1,0,0,0,0. A following DR scan of pattern 1,0,1,1 returns 0,1,0,1 (one-bit BYPASS delay).
- Load IR=USER_IR, shift 41'h1_2345_6789A with `dr_out_ready`=0 -> after UpdDR, `dr_out_valid`=1 and `dr_out_data`=41'h1_2345_6789A. A second Update-DR sets `overrun`=1 and leaves the data unchanged. Raising ready clears valid the next clock.
- USER DR with `dr_in_data`=41'h0AA at Capture-DR -> the first 8 TDO bits are 0,1,0,1,0,1,0,1.
- Drop `jtag_TRSTn` mid-ShDR -> TLR on the next clock and `jtag_TDO_driven`=0. Repeat with `reset` low -> all outputs at reset values in the same cycle.
